// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing and helpers for whole-line/frame sizes and sync windows.
// Shared by the framebuffer streamer and the VGA output stage.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF     = 640;
    localparam int H_FRONT_PORCH_DEF = 16;
    localparam int H_SYNC_PULSE_DEF  = 96;
    localparam int H_BACK_PORCH_DEF  = 48;
    localparam int V_VISIBLE_DEF     = 480;
    localparam int V_FRONT_PORCH_DEF = 10;
    localparam int V_SYNC_PULSE_DEF  = 2;
    localparam int V_BACK_PORCH_DEF  = 33;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fb_state_e;

    function automatic int whole(input int vis, input int fp, input int sp, input int bp);
        return vis + fp + sp + bp;
    endfunction

    function automatic int sync_start(input int vis, input int fp);
        return vis + fp;
    endfunction

    function automatic int sync_end(input int vis, input int fp, input int sp);
        return vis + fp + sp;
    endfunction

    localparam int H_WHOLE_DEF = whole(H_VISIBLE_DEF, H_FRONT_PORCH_DEF, H_SYNC_PULSE_DEF, H_BACK_PORCH_DEF);
    localparam int V_WHOLE_DEF = whole(V_VISIBLE_DEF, V_FRONT_PORCH_DEF, V_SYNC_PULSE_DEF, V_BACK_PORCH_DEF);

endpackage

// File: rtl/vga_raster_counter.sv
// Column/row position over the whole frame, advancing on request, with
// visible-area and sync decode of the current position.
module vga_raster_counter
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE     = H_VISIBLE_DEF,
    parameter int H_FRONT_PORCH = H_FRONT_PORCH_DEF,
    parameter int H_SYNC_PULSE  = H_SYNC_PULSE_DEF,
    parameter int H_BACK_PORCH  = H_BACK_PORCH_DEF,
    parameter int V_VISIBLE     = V_VISIBLE_DEF,
    parameter int V_FRONT_PORCH = V_FRONT_PORCH_DEF,
    parameter int V_SYNC_PULSE  = V_SYNC_PULSE_DEF,
    parameter int V_BACK_PORCH  = V_BACK_PORCH_DEF,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0,
    localparam int H_WHOLE = whole(H_VISIBLE, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH),
    localparam int V_WHOLE = whole(V_VISIBLE, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH),
    localparam int CW_H    = $clog2(H_WHOLE),
    localparam int CW_V    = $clog2(V_WHOLE)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_advance,
    output logic [CW_H-1:0] o_col,
    output logic [CW_V-1:0] o_row,
    output logic            o_origin,
    output logic            o_frame_end,
    output logic            o_visible,
    output logic            o_hsync,
    output logic            o_vsync
);

    // One extra bit so a sync window ending exactly at the whole size still compares correctly.
    localparam logic [CW_H:0] H_LAST = (CW_H+1)'(H_WHOLE - 1);
    localparam logic [CW_H:0] H_VIS  = (CW_H+1)'(H_VISIBLE);
    localparam logic [CW_H:0] HS_B   = (CW_H+1)'(sync_start(H_VISIBLE, H_FRONT_PORCH));
    localparam logic [CW_H:0] HS_E   = (CW_H+1)'(sync_end(H_VISIBLE, H_FRONT_PORCH, H_SYNC_PULSE));
    localparam logic [CW_V:0] V_LAST = (CW_V+1)'(V_WHOLE - 1);
    localparam logic [CW_V:0] V_VIS  = (CW_V+1)'(V_VISIBLE);
    localparam logic [CW_V:0] VS_B   = (CW_V+1)'(sync_start(V_VISIBLE, V_FRONT_PORCH));
    localparam logic [CW_V:0] VS_E   = (CW_V+1)'(sync_end(V_VISIBLE, V_FRONT_PORCH, V_SYNC_PULSE));

    logic [CW_H-1:0] r_col;
    logic [CW_V-1:0] r_row;
    logic [CW_H:0]   w_col;
    logic [CW_V:0]   w_row;
    logic            w_line_end;
    logic            w_row_last;

    assign w_col      = {1'b0, r_col};
    assign w_row      = {1'b0, r_row};
    assign w_line_end = (w_col == H_LAST);
    assign w_row_last = (w_row == V_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_advance) begin
            if (w_line_end) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col       = r_col;
    assign o_row       = r_row;
    assign o_origin    = (r_col == '0) && (r_row == '0);
    assign o_frame_end = w_line_end && w_row_last;
    assign o_visible   = (w_col < H_VIS) && (w_row < V_VIS);
    assign o_hsync     = ((w_col >= HS_B) && (w_col < HS_E)) ? HSYNC_POL : !HSYNC_POL;
    assign o_vsync     = ((w_row >= VS_B) && (w_row < VS_E)) ? VSYNC_POL : !VSYNC_POL;

endmodule

// File: rtl/vga_fb_pixel_stream.sv
// Raster-order framebuffer walker: pipelined AXI-Lite reads for visible pixels,
// locally generated blanking/sync, one pixel per ready/valid beat.
module vga_fb_pixel_stream
    import vga_timing_pkg::*;
#(
    parameter int          AXI_ADDR_WIDTH  = 20,
    parameter int          AXI_DATA_WIDTH  = 16,
    parameter int          COLOR_BITS      = 4,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          H_VISIBLE       = H_VISIBLE_DEF,
    parameter int          H_FRONT_PORCH   = H_FRONT_PORCH_DEF,
    parameter int          H_SYNC_PULSE    = H_SYNC_PULSE_DEF,
    parameter int          H_BACK_PORCH    = H_BACK_PORCH_DEF,
    parameter int          V_VISIBLE       = V_VISIBLE_DEF,
    parameter int          V_FRONT_PORCH   = V_FRONT_PORCH_DEF,
    parameter int          V_SYNC_PULSE    = V_SYNC_PULSE_DEF,
    parameter int          V_BACK_PORCH    = V_BACK_PORCH_DEF,
    parameter bit          HSYNC_POL       = 1'b0,
    parameter bit          VSYNC_POL       = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_hsync,
    output logic                      out_vsync,
    output logic                      out_visible,
    output logic [COLOR_BITS-1:0]     out_red,
    output logic [COLOR_BITS-1:0]     out_green,
    output logic [COLOR_BITS-1:0]     out_blue
);

    localparam int NPIX = H_VISIBLE * V_VISIBLE;
    localparam int IW   = $clog2(NPIX);
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int CB   = COLOR_BITS;
    localparam int DW   = AXI_DATA_WIDTH;
    localparam int CW_H = $clog2(whole(H_VISIBLE, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH));
    localparam int CW_V = $clog2(whole(V_VISIBLE, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH));

    localparam logic [IW-1:0]             IDX_LAST = IW'(NPIX - 1);
    localparam logic [OW-1:0]             MAX_OS   = OW'(MAX_OUTSTANDING);
    localparam logic [AXI_ADDR_WIDTH-1:0] BASE_A   = AXI_ADDR_WIDTH'(BASE_ADDR);

    fb_state_e r_state, w_state_nxt;

    logic [CW_H-1:0]           w_col;
    logic [CW_V-1:0]           w_row;
    logic                      w_origin, w_frame_end_pos, w_vis_pos, w_hs_pos, w_vs_pos;
    logic                      w_run, w_slot, w_load, w_frame_done, w_rready, w_rhs;
    logic                      w_issue_ok, w_present;
    logic [IW-1:0]             r_rd_idx;
    logic                      r_rd_done;
    logic [OW-1:0]             r_inflight;
    logic                      r_arvalid;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic                      r_out_valid, r_out_vis, r_out_hs, r_out_vs;
    logic [CB-1:0]             r_red, r_green, r_blue;
    logic                      w_unused;

    vga_raster_counter #(
        .H_VISIBLE     (H_VISIBLE),
        .H_FRONT_PORCH (H_FRONT_PORCH),
        .H_SYNC_PULSE  (H_SYNC_PULSE),
        .H_BACK_PORCH  (H_BACK_PORCH),
        .V_VISIBLE     (V_VISIBLE),
        .V_FRONT_PORCH (V_FRONT_PORCH),
        .V_SYNC_PULSE  (V_SYNC_PULSE),
        .V_BACK_PORCH  (V_BACK_PORCH),
        .HSYNC_POL     (HSYNC_POL),
        .VSYNC_POL     (VSYNC_POL)
    ) u_pos (
        .clk         (clk),
        .reset       (reset),
        .i_advance   (w_load),
        .o_col       (w_col),
        .o_row       (w_row),
        .o_origin    (w_origin),
        .o_frame_end (w_frame_end_pos),
        .o_visible   (w_vis_pos),
        .o_hsync     (w_hs_pos),
        .o_vsync     (w_vs_pos)
    );

    // Position is the next pixel to load; visible ones wait for their in-order r beat.
    assign w_run        = (r_state == ST_RUN);
    assign w_slot       = !r_out_valid || out_ready;
    assign w_rready     = w_run && w_slot && w_vis_pos;
    assign w_rhs        = w_rready && axi_rvalid;
    assign w_load       = w_run && w_slot && (!w_vis_pos || axi_rvalid);
    assign w_frame_done = w_load && w_frame_end_pos;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (enable && w_origin)      w_state_nxt = ST_RUN;
            ST_RUN:  if (w_frame_done && !enable) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // r_rd_done parks the issuer after the last visible read until the frame is committed.
    assign w_issue_ok = w_run && !r_rd_done && (r_inflight < MAX_OS);
    assign w_present  = w_issue_ok && (!r_arvalid || axi_arready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_arvalid  <= 1'b0;
            r_araddr   <= BASE_A;
            r_rd_idx   <= '0;
            r_rd_done  <= 1'b0;
            r_inflight <= '0;
        end else begin
            if (w_present) begin
                r_arvalid <= 1'b1;
                r_araddr  <= BASE_A + AXI_ADDR_WIDTH'(r_rd_idx);
                if (r_rd_idx == IDX_LAST) begin
                    r_rd_idx  <= '0;
                    r_rd_done <= 1'b1;
                end else begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                end
            end else if (axi_arready) begin
                r_arvalid <= 1'b0;
            end
            if (w_frame_done) r_rd_done <= 1'b0;
            case ({w_present, w_rhs})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_vis   <= 1'b0;
            r_out_hs    <= !HSYNC_POL;
            r_out_vs    <= !VSYNC_POL;
            r_red       <= '0;
            r_green     <= '0;
            r_blue      <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_vis   <= w_vis_pos;
            r_out_hs    <= w_hs_pos;
            r_out_vs    <= w_vs_pos;
            r_red       <= w_vis_pos ? axi_rdata[DW-1 -: CB]      : '0;
            r_green     <= w_vis_pos ? axi_rdata[DW-1-CB -: CB]   : '0;
            r_blue      <= w_vis_pos ? axi_rdata[DW-1-2*CB -: CB] : '0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign w_unused    = ^{axi_rresp, axi_rdata, w_col, w_row};

    assign axi_araddr  = r_araddr;
    assign axi_arvalid = r_arvalid;
    assign axi_rready  = w_rready;
    assign out_valid   = r_out_valid;
    assign out_visible = r_out_vis;
    assign out_hsync   = r_out_hs;
    assign out_vsync   = r_out_vs;
    assign out_red     = r_red;
    assign out_green   = r_green;
    assign out_blue    = r_blue;

endmodule

// File: tb/tb_vga_fb_pixel_stream.sv
// Bench for vga_fb_pixel_stream on a tiny 7x5 raster: in-order AXI-Lite memory
// model plus a position-based pixel reference, with directed and random phases.
module tb_vga_fb_pixel_stream;

    localparam int AW = 20, DW = 16, CB = 4;
    localparam int HV = 4, HF = 1, HS = 1, HB = 1;
    localparam int VV = 2, VF = 1, VS = 1, VB = 1;
    localparam int HW = HV + HF + HS + HB;
    localparam int VW = VV + VF + VS + VB;
    localparam int FRAME = HW * VW;
    localparam int NPIX  = HV * VV;
    localparam int MAXO  = 2;
    localparam int BASE  = 'h100;

    logic          clk = 1'b0;
    logic          reset = 1'b1, enable = 1'b0;
    logic [AW-1:0] axi_araddr;
    logic          axi_arvalid, axi_arready = 1'b0;
    logic [DW-1:0] axi_rdata = '0;
    logic [1:0]    axi_rresp = 2'b00;
    logic          axi_rvalid = 1'b0, axi_rready;
    logic          out_valid, out_ready = 1'b1;
    logic          out_hsync, out_vsync, out_visible;
    logic [CB-1:0] out_red, out_green, out_blue;

    always #5 clk = ~clk;

    vga_fb_pixel_stream #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .COLOR_BITS(CB),
        .BASE_ADDR(BASE), .MAX_OUTSTANDING(MAXO),
        .H_VISIBLE(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB),
        .V_VISIBLE(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready), .out_valid(out_valid), .out_ready(out_ready),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_visible(out_visible),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue)
    );

    logic [15:0]   mem [NPIX];
    logic [AW-1:0] rq [$];
    int  checks = 0, fails = 0;
    int  beat_n = 0, rd_n = 0, ar_total = 0;
    bit  ar_block = 1'b0, rnd = 1'b0;
    bit  ar_hs = 1'b0, r_hs = 1'b0, o_hs = 1'b0;
    bit  prev_ostall = 1'b0, prev_arstall = 1'b0;
    logic [14:0]   held_pix;
    logic [AW-1:0] held_addr, samp_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_mem(input logic [AW-1:0] a);
        int i;
        i = int'(a) - BASE;
        if (i >= 0 && i < NPIX) return mem[i];
        return 16'hDEAD;
    endfunction

    // Expected {visible, hsync, vsync, r, g, b} for frame position p.
    function automatic logic [14:0] exp_pix(input int p);
        int col, row;
        logic vis, hs, vs;
        logic [15:0] d;
        col = p % HW;
        row = p / HW;
        vis = (col < HV) && (row < VV);
        hs  = (col == HV + HF) ? 1'b0 : 1'b1;
        vs  = (row == VV + VF) ? 1'b0 : 1'b1;
        d   = vis ? mem[row * HV + col] : 16'h0;
        return {vis, hs, vs, d[15:4]};
    endfunction

    function automatic logic [14:0] cur_pix();
        return {out_visible, out_hsync, out_vsync, out_red, out_green, out_blue};
    endfunction

    // Memory slave plus output monitor; handshakes are decided mid-low-phase and applied after posedge.
    always begin
        @(negedge clk);
        #1;
        axi_arready = !ar_block && (!rnd || $urandom_range(0, 1) == 1);
        if (reset)                   axi_rvalid = 1'b0;
        else if (axi_rvalid && !r_hs) axi_rvalid = 1'b1;
        else axi_rvalid = (rq.size() > 0) && (!rnd || $urandom_range(0, 2) != 0);
        axi_rdata = (rq.size() > 0) ? rd_mem(rq[0]) : 16'h0;
        #1;
        ar_hs = axi_arvalid && axi_arready;
        r_hs  = axi_rvalid && axi_rready;
        o_hs  = out_valid && out_ready;
        samp_addr = axi_araddr;
        if (!reset) begin
            if (prev_ostall)  chk("out_hold", {out_valid, cur_pix()}, {1'b1, held_pix});
            if (prev_arstall) chk("ar_hold", {axi_arvalid, axi_araddr}, {1'b1, held_addr});
            chk("inflight_le_max", 32'((rq.size() + int'(axi_arvalid)) <= MAXO), 1);
            if (out_valid && !out_ready) chk("rready_stall", axi_rready, 0);
            if (ar_hs) chk("araddr", axi_araddr, BASE + rd_n % NPIX);
            if (o_hs)  chk("beat", cur_pix(), exp_pix(beat_n % FRAME));
            if (o_hs && beat_n % FRAME == 2) chk("pix_r0c2", {out_red, out_green, out_blue}, 12'hABC);
        end
        prev_ostall  = !reset && out_valid && !out_ready;
        prev_arstall = !reset && axi_arvalid && !axi_arready;
        held_pix  = cur_pix();
        held_addr = axi_araddr;
        @(posedge clk);
        if (reset) begin
            rq.delete();
            beat_n = 0;
            rd_n   = 0;
            r_hs   = 1'b0;
        end else begin
            if (r_hs) void'(rq.pop_front());
            if (ar_hs) begin
                rq.push_back(samp_addr);
                rd_n++;
                ar_total++;
            end
            if (o_hs) beat_n++;
        end
    end

    task automatic check_reset_vals();
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_araddr", axi_araddr, BASE);
        chk("rst_rready", axi_rready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pix", cur_pix(), {1'b0, 1'b1, 1'b1, 12'h000});
    endtask

    task automatic wait_mod(input string tag, input int m);
        int n = 0;
        while (beat_n % FRAME != m && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(beat_n % FRAME), m);
    endtask

    task automatic wait_beats(input string tag, input int cnt);
        int n = 0;
        int target;
        target = beat_n + cnt;
        while (beat_n < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(beat_n >= target), 1);
    endtask

    initial begin
        int a0;
        for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);
        mem[2] = 16'hABC0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;

        wait_beats("frame0", FRAME);
        wait_beats("frame1", FRAME);

        // Hold off address acceptance across a frame start.
        wait_mod("arblk_pos", 33);
        ar_block = 1'b1;
        repeat (10) @(negedge clk);
        ar_block = 1'b0;

        // Downstream stall mid-line.
        wait_mod("stall_pos", 2);
        a0 = ar_total;
        out_ready = 1'b0;
        repeat (20) @(negedge clk);
        chk("stall_reads", 32'(ar_total - a0 <= MAXO), 1);
        out_ready = 1'b1;

        rnd = 1'b1;
        repeat (400) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        rnd = 1'b0;

        // Drop enable mid-frame: the frame completes, then everything goes quiet.
        wait_mod("en_drop_pos", 8);
        enable = 1'b0;
        wait_mod("en_frame_end", 0);
        repeat (20) begin
            @(negedge clk);
            #2;
            chk("idle_quiet", {axi_arvalid, out_valid}, 2'b00);
        end
        enable = 1'b1;
        wait_beats("resume", 12);

        // Reset in the middle of a frame.
        wait_mod("rst_pos", 10);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
        wait_beats("after_reset", FRAME + 5);
        chk("after_reset_reads", 32'(rd_n >= NPIX), 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/vga_fb_pixel_stream.md
Name: vga_fb_pixel_stream

Overview:
- Parametrised successor to the single-outstanding VGA SRAM pixel streamer. Runs in the AXI clock domain and walks a framebuffer in raster order.
- Issues AXI-Lite reads only for visible pixels, with up to MAX_OUTSTANDING reads in flight.
- Generates blanking and sync pixels locally, with no memory access.
- Emits one pixel per ready/valid beat into the CDC FIFO feeding the VGA output stage.

Parameters:
- AXI_ADDR_WIDTH, 20, read address width.
- AXI_DATA_WIDTH, 16, read data width; must be >= 3*COLOR_BITS.
- COLOR_BITS, 4, bits per colour channel.
- BASE_ADDR, 0, framebuffer word address of pixel (0,0).
- MAX_OUTSTANDING, 4, max issued-but-unreturned reads (1..15).
- H_VISIBLE / H_FRONT_PORCH / H_SYNC_PULSE / H_BACK_PORCH: 640 / 16 / 96 / 48.
- V_VISIBLE / V_FRONT_PORCH / V_SYNC_PULSE / V_BACK_PORCH: 480 / 10 / 2 / 33.
- HSYNC_POL, 0, active level of hsync during the pulse.
- VSYNC_POL, 0, active level of vsync during the pulse.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  permits frame start.
- axi_araddr  out  AXI_ADDR_WIDTH  read address.
- axi_arvalid  out  1  read address valid.
- axi_arready  in  1  read address ready.
- axi_rdata  in  AXI_DATA_WIDTH  read data.
- axi_rresp  in  2  read response; ignored.
- axi_rvalid  in  1  read data valid.
- axi_rready  out  1  read data ready.
- out_valid  out  1  pixel valid.
- out_ready  in  1  downstream accepts pixel.
- out_hsync, out_vsync  out  1  sync levels.
- out_visible  out  1  pixel is in the visible area.
- out_red, out_green, out_blue  out  COLOR_BITS  colour; zero when not visible.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: axi_arvalid=0, axi_araddr=BASE_ADDR, axi_rready=0, out_valid=0, colours=0, out_visible=0, out_hsync=!HSYNC_POL, out_vsync=!VSYNC_POL. All counters are 0 and state is IDLE.
- Reset mid-operation: all in-flight reads are abandoned. The bench must not return stale rvalid after reset.
- Frame gating FSM, states IDLE and RUN:
  - IDLE -> RUN when enable=1 and both position counters are at (0,0).
  - In RUN, enable is re-sampled only at frame end (output position wraps to 0,0). If enable=0 there, go to IDLE; otherwise continue.
  - Deasserting enable mid-frame has no effect; the frame always completes.
- Read issuer:
  - A linear counter rd_idx runs 0..H_VISIBLE*V_VISIBLE-1; axi_araddr = BASE_ADDR + rd_idx. No multiplier.
  - rd_idx wraps to 0 after the last visible pixel. Across the wrap, the next frame's reads may issue only once the FSM has committed to that frame.
  - inflight counter: +1 when a read is presented (arvalid rises or a new address is loaded); -1 on an r handshake. Both in the same cycle leave it unchanged.
  - A new read is presented only when inflight < MAX_OUTSTANDING.
  - arvalid is held with a stable address until arready. Back-to-back issue at one per cycle is allowed.
- Output position counter (col, row) over the whole line/frame:
  - Advances by one on each output load, wrapping col at H_WHOLE-1 and row at V_WHOLE-1.
  - H_WHOLE = sum of the H parameters; V_WHOLE likewise.
  - Counter width is clog2 of the whole size.
- Output load condition: (!out_valid || out_ready) and a source is available.
  - Blank position: the source is always available (local generation).
  - Visible position: the source is the r beat; axi_rready = load condition && visible && RUN.
  - Responses return in order, so the k-th visible position consumes the k-th read.
- Output register on load:
  - out_hsync = HSYNC_POL when col is in [H_VISIBLE+H_FP, +H_SYNC), else !HSYNC_POL. out_vsync likewise on row.
  - Colour fields: red = rdata[DW-1 -: CB], green next CB bits, blue next CB bits.
  - out_valid is held with stable data until out_ready.
- Latency:
  - Visible pixel: out_valid asserts the cycle after the r handshake.
  - Blank pixel: out_valid asserts the cycle after load, so blanking streams at 1 pixel/clk.
- Backpressure (out_ready=0): no new loads and rready=0. Reads keep issuing until inflight = MAX_OUTSTANDING, then stall.

Decomposition:
- Shared package vga_timing_pkg holds the default 640x480@60 timing localparams, H_WHOLE/V_WHOLE, and sync start/end computation, shared with the VGA output stage.
- One natural sub-module, vga_raster_counter: col/row counter with advance input, wrap flags, visible/hsync/vsync decode. Instantiated for the output position.

Test Plan:
All tests use small timing: H 4/1/1/1 (H_WHOLE=7), V 2/1/1/1 (V_WHOLE=5), BASE_ADDR=0x100, MAX_OUTSTANDING=2.
- Zero-wait SRAM model, out_ready=1, enable=1 -> 35 beats per frame. Exactly 8 reads at addresses 0x100..0x107. Hsync active on col 5 only; vsync on row 3 only. Blank beats have colour=0.
- Memory holds 0xABC0 at 0x102 -> the beat at row 0, col 2 has red=A, green=B, blue=C, out_visible=1.
- arready held low for 10 cycles -> araddr is stable, inflight never exceeds 2, no rdata is lost.
- out_ready=0 for 20 cycles mid-line -> out_valid and data are held; rready=0; at most 2 reads are issued during the stall.
- enable dropped at row 1, col 1 -> the frame completes (all 35 beats), then no arvalid and no out_valid until enable returns.
- reset pulsed mid-frame -> the next cycle shows all reset values; the restart begins at address 0x100.
